// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg : shared symbol encodings, accumulator states and width helper
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package morse_pkg;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } acc_state_e;

  function automatic int len_width(input int max_symbols);
    return $clog2(max_symbols + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/morse_debounce.sv
// ---------------------------------------------------------------------------
// morse_debounce : 2-flop synchroniser plus debouncer, one-cycle toggle flag
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module morse_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic toggle_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       arm_q, arm_d;
  logic             toggle;

  // While arming, stable tracks the level the synchroniser is about to present,
  // so a key already held when reset releases never looks like a toggle.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    arm_d    = arm_q;
    toggle   = 1'b0;
    if (!arm_q[1]) begin
      arm_d    = arm_q + 2'd1;
      stable_d = sync1_q;
      cnt_d    = '0;
    end else if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      toggle   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      arm_q    <= 2'd0;
    end else begin
      sync1_q  <= key_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      arm_q    <= arm_d;
    end
  end

  assign toggle_o = toggle;

endmodule

`default_nettype wire

// File: rtl/morse_symbol_decoder.sv
// ---------------------------------------------------------------------------
// morse_symbol_decoder : debounced dot/dash keys to variable-length letters
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module morse_symbol_decoder
  import morse_pkg::*;
#(
  parameter  int MAX_SYMBOLS     = 5,
  parameter  int DEBOUNCE_CYCLES = 4,
  parameter  int GAP_CYCLES      = 1000,
  localparam int LEN_W           = len_width(MAX_SYMBOLS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             sw,
  input  logic                   out_ready,
  output logic [MAX_SYMBOLS-1:0] code,
  output logic [LEN_W-1:0]       code_len,
  output logic                   code_valid,
  output logic                   busy,
  output logic                   overflow,
  output logic                   collision
);

  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_SYMBOLS - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_SYMBOLS);

  logic [1:0] ev;

  for (genvar g = 0; g < 2; g++) begin : g_key
    morse_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .key_i   (sw[g]),
      .toggle_o(ev[g])
    );
  end

  acc_state_e             state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [MAX_SYMBOLS-1:0] acc_q, acc_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [MAX_SYMBOLS-1:0] code_q, code_d;
  logic [LEN_W-1:0]       code_len_q, code_len_d;
  logic                   valid_q, valid_d;
  logic                   overflow_q, overflow_d;
  logic                   collision_q, collision_d;

  logic                   sym;
  logic                   done;
  logic [MAX_SYMBOLS-1:0] app_code, done_code;
  logic [LEN_W-1:0]       done_len;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    gap_d       = gap_q;
    code_d      = code_q;
    code_len_d  = code_len_q;
    valid_d     = valid_q;
    overflow_d  = 1'b0;
    collision_d = ev[0] & ev[1];
    done        = 1'b0;
    done_code   = acc_q;
    done_len    = len_q;
    // A simultaneous dot and dash keeps the dot.
    sym         = ev[0] ? SYM_DOT : SYM_DASH;

    app_code = acc_q;
    for (int k = 0; k < MAX_SYMBOLS; k++) begin
      if (len_q == LEN_W'(k)) app_code[MAX_SYMBOLS-1-k] = sym;
    end

    if (|ev) begin
      gap_d = '0;
      if (len_q == LEN_LAST) begin
        done      = 1'b1;
        done_code = app_code;
        done_len  = LEN_MAX;
      end else begin
        acc_d   = app_code;
        len_d   = len_q + LEN_W'(1);
        state_d = ST_COLLECT;
      end
    end else if (state_q == ST_COLLECT) begin
      if (gap_q == GAP_LAST) done = 1'b1;
      else                   gap_d = gap_q + GAP_W'(1);
    end

    if (done) begin
      state_d = ST_IDLE;
      len_d   = '0;
      acc_d   = '0;
      gap_d   = '0;
      if (!valid_q || out_ready) begin
        code_d     = done_code;
        code_len_d = done_len;
        valid_d    = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      gap_q       <= '0;
      code_q      <= '0;
      code_len_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      gap_q       <= gap_d;
      code_q      <= code_d;
      code_len_q  <= code_len_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      collision_q <= collision_d;
    end
  end

  assign code       = code_q;
  assign code_len   = code_len_q;
  assign code_valid = valid_q;
  assign busy       = (state_q == ST_COLLECT);
  assign overflow   = overflow_q;
  assign collision  = collision_q;

endmodule

`default_nettype wire
